// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode constants, FSM encoding and default width for
//               the ALU command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Default operand/result width of the attached ALU
    localparam int WIDTH_DEFAULT = 8;

    // ALU opcodes; the sequencer passes these through without interpreting them
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_CMP   = 3'b101;
    localparam logic [2:0] OP_SHL_A = 3'b110;
    localparam logic [2:0] OP_SHL_B = 3'b111;

    // Sequencer FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } seq_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_settle_counter.sv
`default_nettype none
// ============================================================================
// Module      : alu_settle_counter
// Description : Loadable down-counter with a zero flag; times how long the
//               operands are held on the ALU before the result is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_settle_counter #(
    parameter int COUNT_W = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [COUNT_W-1:0] cnt_d;
    logic [COUNT_W-1:0] cnt_q;

    // Next count: a load wins over a decrement; the count saturates at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - COUNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule : alu_settle_counter
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Accepts ALU commands on a valid/ready channel, drives the
//               operands onto a combinational ALU, holds them for a settle
//               window, then returns the sampled result, flags, opcode and tag
//               on a response valid/ready channel.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEFAULT,
    parameter int TAG_W         = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    // Command channel
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_opcode,
    input  logic [TAG_W-1:0] cmd_tag,
    // ALU datapath
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_c_flag,
    input  logic             alu_c_out,
    // Response channel
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_c_flag,
    output logic             rsp_c_out,
    output logic [2:0]       rsp_opcode,
    output logic [TAG_W-1:0] rsp_tag,
    // Status
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    // Settle counter width; a window of one cycle still needs one bit
    localparam int               SC_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0]  SC_LOAD = SC_W'(SETTLE_CYCLES - 1);

    // A zero-length settle window cannot sample a meaningful result
    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("alu_cmd_sequencer: SETTLE_CYCLES must be at least 1");
        end
    endgenerate

    seq_state_e       state_d,      state_q;
    logic [WIDTH-1:0] alu_a_d,      alu_a_q;
    logic [WIDTH-1:0] alu_b_d,      alu_b_q;
    logic [2:0]       alu_op_d,     alu_op_q;
    logic [TAG_W-1:0] tag_d,        tag_q;
    logic             rsp_valid_d,  rsp_valid_q;
    logic [WIDTH-1:0] rsp_result_d, rsp_result_q;
    logic             rsp_c_flag_d, rsp_c_flag_q;
    logic             rsp_c_out_d,  rsp_c_out_q;
    logic [2:0]       rsp_op_d,     rsp_op_q;
    logic [TAG_W-1:0] rsp_tag_d,    rsp_tag_q;
    logic [CNT_W-1:0] ops_done_d,   ops_done_q;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;

    alu_settle_counter #(
        .COUNT_W (SC_W)
    ) u_settle_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (SC_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state and datapath capture: every register holds unless its state acts on it
    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        tag_d        = tag_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_c_flag_d = rsp_c_flag_q;
        rsp_c_out_d  = rsp_c_out_q;
        rsp_op_d     = rsp_op_q;
        rsp_tag_d    = rsp_tag_q;
        ops_done_d   = ops_done_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    alu_a_d  = cmd_a;
                    alu_b_d  = cmd_b;
                    alu_op_d = cmd_opcode;
                    tag_d    = cmd_tag;
                    cnt_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    rsp_result_d = alu_result;
                    rsp_c_flag_d = alu_c_flag;
                    rsp_c_out_d  = alu_c_out;
                    rsp_op_d     = alu_op_q;
                    rsp_tag_d    = tag_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ops_done_d  = ops_done_q + CNT_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            tag_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_c_flag_q <= 1'b0;
            rsp_c_out_q  <= 1'b0;
            rsp_op_q     <= '0;
            rsp_tag_q    <= '0;
            ops_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            tag_q        <= tag_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_c_flag_q <= rsp_c_flag_d;
            rsp_c_out_q  <= rsp_c_out_d;
            rsp_op_q     <= rsp_op_d;
            rsp_tag_q    <= rsp_tag_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_c_flag = rsp_c_flag_q;
    assign rsp_c_out  = rsp_c_out_q;
    assign rsp_opcode = rsp_op_q;
    assign rsp_tag    = rsp_tag_q;
    assign ops_done   = ops_done_q;

endmodule : alu_cmd_sequencer
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Scoreboard bench for alu_cmd_sequencer. Two instances share
//               the clock: one with a one-cycle settle window, one with three.
//               A behavioural ALU closes the loop on each instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int TW = 4;
    localparam int CW = 16;

    typedef struct {
        logic [W-1:0]  res;
        logic          cf;
        logic          co;
        logic [2:0]    op;
        logic [TW-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst        [2];
    logic          cmd_valid  [2];
    logic          cmd_ready  [2];
    logic [W-1:0]  cmd_a      [2];
    logic [W-1:0]  cmd_b      [2];
    logic [2:0]    cmd_opcode [2];
    logic [TW-1:0] cmd_tag    [2];
    logic [W-1:0]  alu_a      [2];
    logic [W-1:0]  alu_b      [2];
    logic [2:0]    alu_opcode [2];
    logic [W-1:0]  alu_result [2];
    logic          alu_c_flag [2];
    logic          alu_c_out  [2];
    logic          rsp_valid  [2];
    logic          rsp_ready  [2];
    logic [W-1:0]  rsp_result [2];
    logic          rsp_c_flag [2];
    logic          rsp_c_out  [2];
    logic [2:0]    rsp_opcode [2];
    logic [TW-1:0] rsp_tag    [2];
    logic          busy       [2];
    logic [CW-1:0] ops_done   [2];

    int   total = 0;
    int   bad   = 0;
    int   exp_done [2];
    exp_t q0 [$];
    exp_t q1 [$];

    alu_cmd_sequencer #(.WIDTH(W), .TAG_W(TW), .SETTLE_CYCLES(1), .CNT_W(CW)) u_dut1 (
        .clk(clk), .rst(rst[0]),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]),
        .cmd_opcode(cmd_opcode[0]), .cmd_tag(cmd_tag[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_opcode(alu_opcode[0]),
        .alu_result(alu_result[0]), .alu_c_flag(alu_c_flag[0]), .alu_c_out(alu_c_out[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
        .rsp_c_flag(rsp_c_flag[0]), .rsp_c_out(rsp_c_out[0]), .rsp_opcode(rsp_opcode[0]),
        .rsp_tag(rsp_tag[0]), .busy(busy[0]), .ops_done(ops_done[0])
    );

    alu_cmd_sequencer #(.WIDTH(W), .TAG_W(TW), .SETTLE_CYCLES(3), .CNT_W(CW)) u_dut3 (
        .clk(clk), .rst(rst[1]),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]),
        .cmd_opcode(cmd_opcode[1]), .cmd_tag(cmd_tag[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_opcode(alu_opcode[1]),
        .alu_result(alu_result[1]), .alu_c_flag(alu_c_flag[1]), .alu_c_out(alu_c_out[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
        .rsp_c_flag(rsp_c_flag[1]), .rsp_c_out(rsp_c_out[1]), .rsp_opcode(rsp_opcode[1]),
        .rsp_tag(rsp_tag[1]), .busy(busy[1]), .ops_done(ops_done[1])
    );

    // Behavioural 8-bit ALU returning {C_out, C_flag, result}
    function automatic logic [W+1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [2:0] op);
        logic [W:0]   t;
        logic [W-1:0] r;
        logic         cf;
        logic         co;
        t  = '0;
        r  = '0;
        cf = 1'b0;
        co = 1'b0;
        case (op)
            OP_ADD:   begin t = {1'b0, a} + {1'b0, b}; r = t[W-1:0]; co = t[W]; cf = co; end
            OP_SUB:   begin t = {1'b0, a} - {1'b0, b}; r = t[W-1:0]; co = t[W]; cf = co; end
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_CMP:   begin r = (a > b) ? W'(1) : W'(0); cf = (a > b); end
            OP_SHL_A: begin t = {a, 1'b0}; r = t[W-1:0]; co = t[W]; cf = co; end
            default:  begin t = {b, 1'b0}; r = t[W-1:0]; co = t[W]; cf = co; end
        endcase
        return {co, cf, r};
    endfunction

    always_comb {alu_c_out[0], alu_c_flag[0], alu_result[0]} = alu_model(alu_a[0], alu_b[0], alu_opcode[0]);
    always_comb {alu_c_out[1], alu_c_flag[1], alu_result[1]} = alu_model(alu_a[1], alu_b[1], alu_opcode[1]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pops the expected response for a handshake about to complete and compares it
    task automatic mon(input int idx);
        exp_t e;
        if (idx == 0) begin
            if (q0.size() == 0) begin chk("dut1_unexpected_rsp", 1, 0); return; end
            e = q0.pop_front();
        end else begin
            if (q1.size() == 0) begin chk("dut3_unexpected_rsp", 1, 0); return; end
            e = q1.pop_front();
        end
        chk($sformatf("u%0d_rsp_result", idx), 32'(rsp_result[idx]), 32'(e.res));
        chk($sformatf("u%0d_rsp_c_flag", idx), 32'(rsp_c_flag[idx]), 32'(e.cf));
        chk($sformatf("u%0d_rsp_c_out", idx),  32'(rsp_c_out[idx]),  32'(e.co));
        chk($sformatf("u%0d_rsp_opcode", idx), 32'(rsp_opcode[idx]), 32'(e.op));
        chk($sformatf("u%0d_rsp_tag", idx),    32'(rsp_tag[idx]),    32'(e.tag));
        chk($sformatf("u%0d_ops_done_pre", idx), 32'(ops_done[idx]), 32'(exp_done[idx]));
        chk($sformatf("u%0d_cmd_ready_in_resp", idx), 32'(cmd_ready[idx]), 0);
        exp_done[idx] = exp_done[idx] + 1;
    endtask

    // Response monitors: a handshake will complete at the next rising edge
    always @(negedge clk) begin
        if (rst[0] === 1'b0 && rsp_valid[0] === 1'b1 && rsp_ready[0] === 1'b1) mon(0);
    end
    always @(negedge clk) begin
        if (rst[1] === 1'b0 && rsp_valid[1] === 1'b1 && rsp_ready[1] === 1'b1) mon(1);
    end

    task automatic chk_reset(input int idx);
        chk($sformatf("u%0d_rst_cmd_ready", idx),  32'(cmd_ready[idx]),  1);
        chk($sformatf("u%0d_rst_busy", idx),       32'(busy[idx]),       0);
        chk($sformatf("u%0d_rst_rsp_valid", idx),  32'(rsp_valid[idx]),  0);
        chk($sformatf("u%0d_rst_alu_a", idx),      32'(alu_a[idx]),      0);
        chk($sformatf("u%0d_rst_alu_b", idx),      32'(alu_b[idx]),      0);
        chk($sformatf("u%0d_rst_alu_opcode", idx), 32'(alu_opcode[idx]), 0);
        chk($sformatf("u%0d_rst_rsp_result", idx), 32'(rsp_result[idx]), 0);
        chk($sformatf("u%0d_rst_rsp_flags", idx),  32'({rsp_c_flag[idx], rsp_c_out[idx]}), 0);
        chk($sformatf("u%0d_rst_rsp_opcode", idx), 32'(rsp_opcode[idx]), 0);
        chk($sformatf("u%0d_rst_rsp_tag", idx),    32'(rsp_tag[idx]),    0);
        chk($sformatf("u%0d_rst_ops_done", idx),   32'(ops_done[idx]),   0);
    endtask

    // Issues one command; when track is set, pushes the hand-computed response
    // and follows the operation until rsp_valid rises, checking hold and latency
    task automatic send(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic [TW-1:0] tag,
                        input logic [W-1:0] er, input logic ecf, input logic eco, input bit track);
        int   n;
        int   lat;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (cmd_ready[idx] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk($sformatf("u%0d_cmd_ready_timeout", idx), 0, 1);
            return;
        end
        cmd_valid[idx]  = 1'b1;
        cmd_a[idx]      = a;
        cmd_b[idx]      = b;
        cmd_opcode[idx] = op;
        cmd_tag[idx]    = tag;
        @(posedge clk);
        if (track) begin
            e.res = er; e.cf = ecf; e.co = eco; e.op = op; e.tag = tag;
            if (idx == 0) q0.push_back(e); else q1.push_back(e);
        end
        #1;
        cmd_valid[idx]  = 1'b0;
        cmd_a[idx]      = 'x;
        cmd_b[idx]      = 'x;
        cmd_opcode[idx] = 'x;
        cmd_tag[idx]    = 'x;
        if (!track) return;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            chk($sformatf("u%0d_alu_a_hold", idx),  32'(alu_a[idx]),      32'(a));
            chk($sformatf("u%0d_alu_b_hold", idx),  32'(alu_b[idx]),      32'(b));
            chk($sformatf("u%0d_alu_op_hold", idx), 32'(alu_opcode[idx]), 32'(op));
            chk($sformatf("u%0d_busy", idx),        32'(busy[idx]),       1);
            chk($sformatf("u%0d_cmd_ready_low", idx), 32'(cmd_ready[idx]), 0);
        end while (rsp_valid[idx] !== 1'b1 && lat < 40);
        chk($sformatf("u%0d_latency", idx), 32'(lat), (idx == 0) ? 32'd2 : 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        exp_done[0] = 0;
        exp_done[1] = 0;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; cmd_valid[i] = 1'b0; rsp_ready[i] = 1'b1;
            cmd_a[i] = '0; cmd_b[i] = '0; cmd_opcode[i] = '0; cmd_tag[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Single ADD, then ops_done after the handshake
        send(0, 8'd50, 8'd40, OP_ADD, 4'd3, 8'd90, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("u0_ops_done_after_add", 32'(ops_done[0]), 1);

        // AND then OR back-to-back
        send(0, 8'h17, 8'h1E, OP_AND, 4'd5, 8'h16, 1'b0, 1'b0, 1'b1);
        send(0, 8'h41, 8'h02, OP_OR,  4'd6, 8'h43, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("u0_ops_done_after_or", 32'(ops_done[0]), 3);

        // Compare and shifts, plus carry/borrow cases
        send(0, 8'd10,  8'd5,  OP_CMP,   4'd7,  8'h01, 1'b1, 1'b0, 1'b1);
        send(0, 8'h0A,  8'h00, OP_SHL_A, 4'd8,  8'h14, 1'b0, 1'b0, 1'b1);
        send(0, 8'h00,  8'h05, OP_SHL_B, 4'd9,  8'h0A, 1'b0, 1'b0, 1'b1);
        send(0, 8'hF0,  8'h20, OP_ADD,   4'd10, 8'h10, 1'b1, 1'b1, 1'b1);
        send(0, 8'h05,  8'h0A, OP_SUB,   4'd11, 8'hFB, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("u0_alu_a_idle_hold", 32'(alu_a[0]), 32'h05);
        chk("u0_alu_b_idle_hold", 32'(alu_b[0]), 32'h0A);
        chk("u0_cmd_ready_idle",  32'(cmd_ready[0]), 1);

        // Backpressure: response must stay put for 5 cycles without ready
        rsp_ready[0] = 1'b0;
        send(0, 8'h21, 8'h53, OP_XOR, 4'd12, 8'h72, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("u0_bp_rsp_valid",  32'(rsp_valid[0]),  1);
            chk("u0_bp_rsp_result", 32'(rsp_result[0]), 32'h72);
            chk("u0_bp_rsp_tag",    32'(rsp_tag[0]),    32'd12);
            chk("u0_bp_alu_a",      32'(alu_a[0]),      32'h21);
            chk("u0_bp_alu_b",      32'(alu_b[0]),      32'h53);
            chk("u0_bp_alu_op",     32'(alu_opcode[0]), 32'(OP_XOR));
            chk("u0_bp_ops_done",   32'(ops_done[0]),   8);
        end
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("u0_post_hs_valid",    32'(rsp_valid[0]),  0);
        chk("u0_post_hs_result",   32'(rsp_result[0]), 32'h72);
        chk("u0_post_hs_ops_done", 32'(ops_done[0]),   9);

        // Three-cycle settle window
        send(1, 8'h12, 8'h34, OP_ADD, 4'd1, 8'h46, 1'b0, 1'b0, 1'b1);
        send(1, 8'hFF, 8'h01, OP_ADD, 4'd2, 8'h00, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("u1_ops_done_before_rst", 32'(ops_done[1]), 2);

        // Reset while in SETTLE: nothing may come out
        send(1, 8'h33, 8'h44, OP_XOR, 4'd4, 8'h77, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("u1_busy_in_settle", 32'(busy[1]), 1);
        rst[1] = 1'b1;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        exp_done[1] = 0;
        @(negedge clk);
        chk_reset(1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("u1_no_rsp_after_rst", 32'(rsp_valid[1]), 0);
        end
        send(1, 8'd3, 8'd4, OP_ADD, 4'd5, 8'd7, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("u1_ops_done_after_recover", 32'(ops_done[1]), 1);

        repeat (3) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);
        chk("u0_ops_done_final", 32'(ops_done[0]), 32'(exp_done[0]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_cmd_sequencer
`default_nettype wire
